toggle_rate_meter: RTL
======================

# toggle_rate_meter

Downstream consumer of the T flip-flop output. Counts level transitions on a toggling input `q_in` over a programmable window of clock cycles and returns the result over a valid/ready handshake. Used to confirm toggle activity, for example how many times the T stage flipped in N cycles, without inspecting waveforms.

## Interface
- `CNT_W`, default 8: width of the transition count, which saturates at 2^CNT_W−1.
- `WINDOW`, default 16: measurement window length in clock cycles; ≥1.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `q_in` input 1: monitored toggle output (T flip-flop `q`).
- `win_start` input 1: one-cycle request to begin a measurement; ignored while `busy`.
- `busy` output 1: high from window start until the result handshake completes.
- `count_out` output CNT_W: transition count of the last completed window.
- `overflow` output 1: set when the count saturated during the window; qualified by `count_valid`.
- `count_valid` output 1: result available.
- `count_ready` input 1: consumer accepts the result.

## Operation
- Sample path: `s_q` samples `q_in` every cycle. `p_q <= s_q` every cycle. `edge = s_q ^ p_q`. Both edge directions count.
- States: IDLE, COUNT, HOLD.
- IDLE: `busy`=0, `count_valid`=0.
  - `win_start`=1 → COUNT.
  - Internal count and window counter are cleared. Window counter width is `$clog2(WINDOW+1)`.
- COUNT: `busy`=1. Each cycle:
  - If `edge`, count increments.
  - At 2^CNT_W−1, the count holds and the internal sticky overflow is set.
  - The window counter increments.
  - On the cycle the window counter equals WINDOW−1, that cycle's edge is included, `count_out`/`overflow` are latched, and the state moves to HOLD.
- HOLD: `count_valid`=1; `count_out` and `overflow` are stable.
  - `count_valid & count_ready` → IDLE; `count_valid` and `busy` drop the next cycle.
  - `win_start` is ignored.
- `win_start` in the same cycle as the HOLD→IDLE handshake is ignored. A new request must arrive while in IDLE.
- `count_out`/`overflow` keep their last value in IDLE and are not cleared on handshake.
- Reset: all state returns to IDLE. `busy`=0, `count_valid`=0, `count_out`=0, `overflow`=0, `s_q`=`p_q`=0, counters 0.
  - Reset mid-COUNT or mid-HOLD aborts and discards the result.

## Timing
- `win_start` high in cycle 0 → `busy`=1 from cycle 1.
- Edges are counted when detected in cycles 1..WINDOW.
- `count_valid`=1 from cycle WINDOW+1.
- Transition on `q_in` before edge N is detected: edge is seen one cycle after the `q_in` change without the sync option, three cycles after with it.
- Result-to-IDLE: one cycle after the handshake. Minimum restart interval: WINDOW+3 cycles.
- No combinational path from `count_ready` to any output.

## Configuration
- `TOGGLE_RATE_SYNC_EN` defined:
  - `q_in` passes through a 2-flop synchronizer (reset to 0) before `s_q`.
  - Edge detection latency grows by 2 cycles.
  - For asynchronous or foreign-clock sources.
- Not defined: `q_in` is registered directly into `s_q`. The source must be synchronous to `clk`.

## Test plan
- Upstream T flip-flop on the same clock, `t`=1 continuously, WINDOW=16, CNT_W=8; pulse `win_start` → `count_out`=16, `overflow`=0, `count_valid` in cycle 17.
- `t`=0 held (q static) → `count_out`=0, `overflow`=0.
- CNT_W=4, WINDOW=20, q toggling every cycle → `count_out`=15, `overflow`=1.
- `count_ready` low for 5 cycles in HOLD, `win_start` pulsed during HOLD:
  - `count_valid` held, `count_out` stable.
  - After ready, `busy`=0; no second window starts.
- Assert `rst` at window cycle 8 → next cycle `busy`=0, `count_valid`=0, `count_out`=0; no result produced.
- With `TOGGLE_RATE_SYNC_EN`, single `q_in` transition at cycle 0 relative to `win_start`:
  - Counted (`count_out`=1), detected 2 cycles later than in the non-sync build.
  - In a transition placed 1 cycle before window end, it is counted without sync and missed with sync.

Source files
------------

// File: rtl/toggle_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : toggle_rate_meter
// Description : Counts level transitions of a toggling input over a
//               programmable window of WINDOW clock cycles and presents the
//               (saturating) count over a valid/ready handshake.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters  : CNT_W   width of the transition count (saturates at 2^CNT_W-1)
//               WINDOW  measurement window length in cycles (>= 1)
// Ports       : clk          clock, all logic on posedge
//               rst          synchronous active-high reset
//               q_in         monitored toggle signal (T flip-flop q)
//               win_start    one-cycle measurement request, ignored while busy
//               busy         window running or result not yet accepted
//               count_out    transition count of the last completed window
//               overflow     count saturated during the window
//               count_valid  result available
//               count_ready  consumer accepts the result
// Build macro : TOGGLE_RATE_SYNC_EN  inserts a 2-flop synchronizer on q_in
//               (edge detection latency +2 cycles); leave undefined when q_in
//               is synchronous to clk.
// ============================================================================
module toggle_rate_meter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             win_start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready
);

    localparam int                 c_WIN_W    = $clog2(WINDOW + 1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_q_src;
    logic               r_s_q;
    logic               r_p_q;
    logic               w_edge;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [c_WIN_W-1:0] r_win;
    logic [CNT_W-1:0]   w_cnt_new;
    logic               w_ovf_new;
    logic               w_win_last;
    logic [CNT_W-1:0]   r_count_out;
    logic               r_overflow;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------
`ifdef TOGGLE_RATE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= q_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_q_src = r_sync2;
`else
    assign w_q_src = q_in;
`endif

    // Sample and previous-sample registers; any difference is one transition,
    // regardless of direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q <= 1'b0;
            r_p_q <= 1'b0;
        end else begin
            r_s_q <= w_q_src;
            r_p_q <= r_s_q;
        end
    end

    assign w_edge = r_s_q ^ r_p_q;

    // ------------------------------------------------------------------------
    // Saturating count. Overflow marks an edge that could not be counted
    // because the counter was already at its maximum.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cnt_new = r_cnt;
        w_ovf_new = r_ovf;
        if (w_edge) begin
            if (r_cnt == c_CNT_MAX) begin
                w_ovf_new = 1'b1;
            end else begin
                w_cnt_new = r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_win_last = (r_win == c_WIN_LAST);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (win_start)   w_state_nxt = c_COUNT;
            c_COUNT: if (w_win_last)  w_state_nxt = c_HOLD;
            // count_valid is implied by being in HOLD
            c_HOLD:  if (count_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_win       <= '0;
            r_count_out <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                    r_win <= '0;
                end
                c_COUNT: begin
                    r_cnt <= w_cnt_new;
                    r_ovf <= w_ovf_new;
                    r_win <= r_win + c_WIN_W'(1);
                    // The last window cycle's edge is folded in before latching.
                    if (w_win_last) begin
                        r_count_out <= w_cnt_new;
                        r_overflow  <= w_ovf_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode registered state only, so count_ready never reaches an
    // output combinationally.
    assign busy        = (r_state != c_IDLE);
    assign count_valid = (r_state == c_HOLD);
    assign count_out   = r_count_out;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
